serial_subtractor_nbits: RTL and testbench
==========================================

Name: serial_subtractor_nbits

Overview:
- Multi-cycle, bit-serial unsigned/two's-complement subtractor for the calculator datapath. It computes d = a - b one bit per clock, LSB first, through a single full-subtractor cell plus a borrow flip-flop.
- It is the inverse-operation counterpart of the combinational n-bit adder: same operand widths and _i/_o port style, but it trades area for latency.
- A start/busy/done handshake lets the calculator control FSM sequence it.

Parameters:
- width, 8, operand and result width in bits (legal range 1 to 32).

Ports:
- clk_i  input  1  clock; all logic is on the rising edge.
- rstn_i  input  1  reset; synchronous, active-low.
- start_i  input  1  request pulse. It is accepted only in IDLE.
- a_i  input  width  minuend. Sampled only at the accepting edge.
- b_i  input  width  subtrahend. Sampled only at the accepting edge.
- busy_o  output  1  high while bits are being processed.
- done_o  output  1  one-cycle pulse; results are valid when it is high.
- d_o  output  width  difference a - b, modulo 2^width.
- bout_o  output  1  final borrow; 1 when a < b unsigned.
- ovf_o  output  1  signed overflow of the two's-complement subtraction.

Behaviour:
- Reset: when rstn_i = 0 at an edge, the following are set:
  - state = IDLE;
  - busy_o = 0, done_o = 0;
  - d_o = 0, bout_o = 0, ovf_o = 0;
  - internal shift registers, borrow and bit counter cleared.
- Reset has priority over every other event and aborts any operation in progress. No done_o is produced for an aborted operation.
- State IDLE:
  - start_i = 1 at edge E0 latches a_i and b_i into shift registers A and B.
  - The same edge latches the operand MSBs a_msb and b_msb, clears borrow and counter, and moves to RUN with busy_o = 1.
- State RUN: at each edge E1..Ewidth:
  - Bit computation: x = A[0], y = B[0], bit = x ^ y ^ br, br_next = (~x & y) | (~(x ^ y) & br).
  - Shift updates: bit is shifted into the MSB of the internal result register R, and A and B shift right. The counter increments.
  - At edge Ewidth (counter reaches width-1 before that edge) the FSM moves to DONE.
  - That same edge loads d_o with the final R, bout_o with br_next and ovf_o. It also sets done_o = 1 and busy_o = 0.
- Overflow: ovf_o = (a_msb != b_msb) & (d_msb != a_msb), where d_msb is the final MSB of the result.
- State DONE lasts exactly one cycle. At the next edge done_o returns to 0 and the FSM goes to IDLE.
- Latency: done_o is high in the cycle after edge E(width), i.e. exactly width cycles after the accepting edge.
- Throughput: one operation every width+2 cycles.
- Output stability: d_o, bout_o and ovf_o change only at the completion edge or on reset. They hold their last result through IDLE and through the whole of the next RUN.
- start_i sampled in RUN or DONE is ignored; it is neither queued nor does it corrupt the operation in flight. A start_i held high continuously is accepted at the first IDLE edge.
- a_i and b_i may change freely after the accepting edge without effect.
- width = 1: RUN lasts one edge, and the results match a 1-bit subtract with borrow out.
- No illegal states: any unused state encoding returns to IDLE at the next edge.

Test Plan:
1. width=8, a=200, b=55, start pulse → done_o high exactly 8 cycles after the accepting edge, d_o=145 (0x91), bout_o=0, ovf_o=0. busy_o is high for exactly 8 cycles; done_o is high for exactly 1 cycle.
2. a=5, b=10 → d_o=0xFB, bout_o=1, ovf_o=0.
3. a=0x80, b=0x01 → d_o=0x7F, bout_o=0, ovf_o=1. Also a=0x7F, b=0xFF → d_o=0x80, bout_o=1, ovf_o=1.
4. a=b=0xA5 → d_o=0x00, bout_o=0, ovf_o=0. Then, while busy, drive start_i=1 with a=1, b=1 and change a_i/b_i each cycle → the first result is unaffected. Only one done_o pulse occurs before the FSM returns to IDLE.
5. Start a=0x3C, b=0x11, and drop rstn_i for one edge after 3 RUN edges → the next cycle has all outputs 0, busy_o=0, and no done_o. A fresh start with a=0x3C, b=0x11 then yields d_o=0x2B.
6. 200 back-to-back random operations (start reasserted in the cycle after each done_o) → every d_o equals (a-b) mod 256, bout_o equals (a<b), and ovf_o matches the signed reference. Repeat with width=1 (all 4 operand pairs) and width=16.

Source files
------------

// File: rtl/serial_subtractor_nbits.sv
// Bit-serial subtractor: d = a - b, one bit per clock, LSB first, through a
// single full-subtractor cell and a borrow flip-flop. A start/busy/done
// handshake lets the calculator control FSM sequence it.
//
//   state  | meaning
//   IDLE   | waiting for start_i; outputs hold the last result
//   RUN    | shifting one operand bit pair per edge through the cell
//   DONE   | one-cycle done_o pulse; results valid
module serial_subtractor_nbits #(
  parameter int width = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             start_i,
  input  logic [width-1:0] a_i,
  input  logic [width-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [width-1:0] d_o,
  output logic             bout_o,
  output logic             ovf_o
);

  localparam int CW = (width > 1) ? $clog2(width) : 1;
  localparam logic [CW-1:0] LAST = CW'(width - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [width-1:0] r_a;
  logic [width-1:0] r_b;
  logic [width-1:0] r_r;
  logic [width-1:0] r_d;
  logic [CW-1:0]    r_cnt;
  logic             r_br;
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_busy;
  logic             r_done;
  logic             r_bout;
  logic             r_ovf;

  logic             w_x;
  logic             w_y;
  logic             w_bit;
  logic             w_br_next;
  logic             w_last;
  logic             w_ovf;
  logic [width-1:0] w_bit_msb;
  logic [width-1:0] w_r_next;

  // Full-subtractor cell and the next value of the result shift register.
  // The new bit is placed in the MSB through a one-hot mask so the same
  // expression also works for a 1-bit datapath.
  always_comb begin
    w_x       = r_a[0];
    w_y       = r_b[0];
    w_bit     = w_x ^ w_y ^ r_br;
    w_br_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
    w_bit_msb = '0;
    w_bit_msb[width-1] = w_bit;
    w_r_next  = (r_r >> 1) | w_bit_msb;
    w_last    = (r_state == S_RUN) && (r_cnt == LAST);
    // On the last edge w_bit is the result MSB.
    w_ovf     = (r_a_msb != r_b_msb) & (w_bit != r_a_msb);
  end

  // Next-state logic; unused encodings fall back to IDLE.
  always_comb begin
    w_state_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_state_next = start_i ? S_RUN : S_IDLE;
      S_RUN:   w_state_next = w_last ? S_DONE : S_RUN;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Datapath: operand capture, serial shifting, and result/flag loading.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_a     <= '0;
      r_b     <= '0;
      r_r     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_br    <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_a     <= a_i;
            r_b     <= b_i;
            r_a_msb <= a_i[width-1];
            r_b_msb <= b_i[width-1];
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_r   <= w_r_next;
          r_br  <= w_br_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_d    <= w_r_next;
            r_bout <= w_br_next;
            r_ovf  <= w_ovf;
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = r_busy;
  assign done_o = r_done;
  assign d_o    = r_d;
  assign bout_o = r_bout;
  assign ovf_o  = r_ovf;

endmodule

// File: tb/tb_serial_subtractor_nbits.sv
// Directed and random checks of the bit-serial subtractor at widths 8, 1, 16.
module tb_serial_subtractor_nbits;

  logic        clk;
  logic        rstn;
  logic [2:0]  start_v;
  logic [2:0]  busy_v;
  logic [2:0]  done_v;
  logic [2:0]  bout_v;
  logic [2:0]  ovf_v;
  logic [7:0]  a8, b8, d8;
  logic [0:0]  a1, b1, d1;
  logic [15:0] a16, b16, d16;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [31:0] last_d    [3];
  logic        last_bout [3];
  logic        last_ovf  [3];

  serial_subtractor_nbits #(.width(8)) u_w8 (
    .clk_i(clk), .rstn_i(rstn), .start_i(start_v[0]), .a_i(a8), .b_i(b8),
    .busy_o(busy_v[0]), .done_o(done_v[0]), .d_o(d8), .bout_o(bout_v[0]), .ovf_o(ovf_v[0]));

  serial_subtractor_nbits #(.width(1)) u_w1 (
    .clk_i(clk), .rstn_i(rstn), .start_i(start_v[1]), .a_i(a1), .b_i(b1),
    .busy_o(busy_v[1]), .done_o(done_v[1]), .d_o(d1), .bout_o(bout_v[1]), .ovf_o(ovf_v[1]));

  serial_subtractor_nbits #(.width(16)) u_w16 (
    .clk_i(clk), .rstn_i(rstn), .start_i(start_v[2]), .a_i(a16), .b_i(b16),
    .busy_o(busy_v[2]), .done_o(done_v[2]), .d_o(d16), .bout_o(bout_v[2]), .ovf_o(ovf_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wid(input int u);
    case (u)
      0:       return 8;
      1:       return 1;
      default: return 16;
    endcase
  endfunction

  function automatic logic [31:0] get_d(input int u);
    case (u)
      0:       return {24'b0, d8};
      1:       return {31'b0, d1};
      default: return {16'b0, d16};
    endcase
  endfunction

  task automatic drive(input int u, input logic [31:0] a, input logic [31:0] b);
    case (u)
      0:       begin a8  = a[7:0];  b8  = b[7:0];  end
      1:       begin a1  = a[0:0];  b1  = b[0:0];  end
      default: begin a16 = a[15:0]; b16 = b[15:0]; end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference using signed arithmetic on wide integers.
  task automatic model(input int w, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] d, output logic bo, output logic ov);
    longint full, half, sa, sb, diff;
    full = longint'(1) << w;
    half = longint'(1) << (w - 1);
    d    = 32'((longint'(a) - longint'(b)) & (full - 1));
    bo   = (a < b);
    sa   = (longint'(a) >= half) ? longint'(a) - full : longint'(a);
    sb   = (longint'(b) >= half) ? longint'(b) - full : longint'(b);
    diff = sa - sb;
    ov   = (diff < -half) || (diff > half - 1);
  endtask

  // Starts in an IDLE cycle (#1 after an edge) and ends #1 after the
  // DONE->IDLE edge. Checks timing, output hold, and the final result.
  task automatic op(input int u, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] ed, input logic eb, input logic eo,
                    input bit noisy, input string tag);
    int w;
    w = wid(u);
    start_v[u] = 1'b1;
    drive(u, a, b);
    @(posedge clk); #1;
    start_v[u] = 1'b0;
    for (int k = 1; k <= w; k++) begin
      chk({tag, " busy_run"}, 32'(busy_v[u]), 32'd1);
      chk({tag, " done_run"}, 32'(done_v[u]), 32'd0);
      chk({tag, " d_hold"}, get_d(u), last_d[u]);
      if (noisy) start_v[u] = 1'b1;
      drive(u, $urandom, $urandom);
      @(posedge clk); #1;
    end
    start_v[u] = 1'b0;
    chk({tag, " done"}, 32'(done_v[u]), 32'd1);
    chk({tag, " busy_off"}, 32'(busy_v[u]), 32'd0);
    chk({tag, " d"}, get_d(u), ed);
    chk({tag, " bout"}, 32'(bout_v[u]), 32'(eb));
    chk({tag, " ovf"}, 32'(ovf_v[u]), 32'(eo));
    last_d[u] = ed; last_bout[u] = eb; last_ovf[u] = eo;
    @(posedge clk); #1;
    chk({tag, " done_pulse"}, 32'(done_v[u]), 32'd0);
    chk({tag, " idle_busy"}, 32'(busy_v[u]), 32'd0);
  endtask

  task automatic rand_op(input int u, input string tag);
    logic [31:0] a, b, ed, mask;
    logic eb, eo;
    mask = (wid(u) == 32) ? 32'hFFFF_FFFF : ((32'd1 << wid(u)) - 32'd1);
    a = $urandom & mask;
    b = $urandom & mask;
    model(wid(u), a, b, ed, eb, eo);
    op(u, a, b, ed, eb, eo, 1'b0, tag);
  endtask

  initial begin
    rstn = 1'b0;
    start_v = 3'b000;
    a8 = '0; b8 = '0; a1 = '0; b1 = '0; a16 = '0; b16 = '0;
    for (int i = 0; i < 3; i++) begin
      last_d[i] = '0; last_bout[i] = 1'b0; last_ovf[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      chk("rst busy", 32'(busy_v[u]), 32'd0);
      chk("rst done", 32'(done_v[u]), 32'd0);
      chk("rst d", get_d(u), 32'd0);
      chk("rst bout", 32'(bout_v[u]), 32'd0);
      chk("rst ovf", 32'(ovf_v[u]), 32'd0);
    end
    rstn = 1'b1;
    @(posedge clk); #1;

    op(0, 200, 55, 32'h91, 1'b0, 1'b0, 1'b0, "t1 200-55");
    op(0, 5, 10, 32'hFB, 1'b1, 1'b0, 1'b0, "t2 5-10");
    op(0, 32'h80, 32'h01, 32'h7F, 1'b0, 1'b1, 1'b0, "t3 80-01");
    op(0, 32'h7F, 32'hFF, 32'h80, 1'b1, 1'b1, 1'b0, "t3 7F-FF");

    // Abort after three RUN edges; outputs were 0x80/1/1 before this.
    start_v[0] = 1'b1;
    drive(0, 32'h3C, 32'h11);
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    chk("t5 abort d", get_d(0), 32'd0);
    chk("t5 abort bout", 32'(bout_v[0]), 32'd0);
    chk("t5 abort ovf", 32'(ovf_v[0]), 32'd0);
    chk("t5 abort busy", 32'(busy_v[0]), 32'd0);
    chk("t5 abort done", 32'(done_v[0]), 32'd0);
    for (int i = 0; i < 3; i++) begin
      last_d[i] = '0; last_bout[i] = 1'b0; last_ovf[i] = 1'b0;
    end
    repeat (10) begin
      @(posedge clk); #1;
      chk("t5 no done", 32'(done_v[0]), 32'd0);
      chk("t5 no busy", 32'(busy_v[0]), 32'd0);
    end
    op(0, 32'h3C, 32'h11, 32'h2B, 1'b0, 1'b0, 1'b0, "t5 3C-11");

    op(0, 32'hA5, 32'hA5, 32'h00, 1'b0, 1'b0, 1'b1, "t4 A5-A5");
    repeat (3) begin
      @(posedge clk); #1;
      chk("t4 stays idle", 32'(busy_v[0]), 32'd0);
      chk("t4 single done", 32'(done_v[0]), 32'd0);
    end

    op(1, 0, 0, 0, 1'b0, 1'b0, 1'b0, "w1 0-0");
    op(1, 0, 1, 1, 1'b1, 1'b1, 1'b0, "w1 0-1");
    op(1, 1, 0, 1, 1'b0, 1'b0, 1'b0, "w1 1-0");
    op(1, 1, 1, 0, 1'b0, 1'b0, 1'b0, "w1 1-1");

    op(2, 32'h1234, 32'h0235, 32'h0FFF, 1'b0, 1'b0, 1'b0, "w16 1234-0235");
    op(2, 32'h8000, 32'h0001, 32'h7FFF, 1'b0, 1'b1, 1'b0, "w16 8000-0001");
    op(2, 32'h0000, 32'hFFFF, 32'h0001, 1'b1, 1'b0, 1'b0, "w16 0-FFFF");

    for (int i = 0; i < 200; i++) rand_op(0, "rand w8");
    for (int i = 0; i < 40; i++)  rand_op(2, "rand w16");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
